// File: rtl/rv_fifo_defs.sv
// rv_fifo_defs: width helpers and pointer wrap for rv_elastic_fifo
package rv_fifo_defs;
   function automatic int addr_w(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction
   function automatic int size_w(input int size);
      return $clog2(size + 1);
   endfunction
   // Explicit wrap so non-power-of-two depths never rely on overflow
   function automatic int wrap_inc(input int ptr, input int size);
      return (ptr == size - 1) ? 0 : ptr + 1;
   endfunction
endpackage

// File: rtl/rv_elastic_fifo_ram.sv
// RV_dp_ram: dual-port storage, synchronous write, asynchronous read
module RV_dp_ram #(
   parameter int DATAW = 32,
   parameter int SIZE  = 16,
   parameter int ADDRW = 4
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [ADDRW-1:0] i_waddr,
   input  logic [DATAW-1:0] i_wdata,
   input  logic [ADDRW-1:0] i_raddr,
   output logic [DATAW-1:0] o_rdata
);
   logic [DATAW-1:0] r_mem [SIZE];
   always_ff @(posedge i_clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/rv_elastic_fifo.sv
// rv_elastic_fifo: valid/ready FWFT FIFO with thresholds, flush and high-watermark
module rv_elastic_fifo
   import rv_fifo_defs::*;
#(
   parameter int DATAW   = 32,
   parameter int SIZE    = 16,
   parameter bit OUT_REG = 1'b0,
   parameter int ADDRW   = addr_w(SIZE),
   parameter int SIZEW   = size_w(SIZE)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_flush,
   input  logic             i_in_valid,
   input  logic [DATAW-1:0] i_in_data,
   output logic             o_in_ready,
   output logic             o_out_valid,
   output logic [DATAW-1:0] o_out_data,
   input  logic             i_out_ready,
   input  logic [SIZEW-1:0] i_alm_full_thr,
   input  logic [SIZEW-1:0] i_alm_empty_thr,
   output logic             o_full,
   output logic             o_alm_full,
   output logic             o_alm_empty,
   output logic [SIZEW-1:0] o_size,
   output logic [SIZEW-1:0] o_max_size
);
   logic [SIZEW-1:0] r_count, r_max, w_count_nxt;
   logic [ADDRW-1:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
   logic             r_full, r_alm_full, r_alm_empty;
   logic [DATAW-1:0] r_dout, w_rdata;
   logic             w_push, w_pop, w_bypass, w_ram_we, w_rd_adv;
   // With OUT_REG the head lives in r_dout and the RAM holds only the entries behind it
   always_comb begin
      w_push      = i_in_valid & ~r_full & ~i_flush;
      w_pop       = (r_count != '0) & i_out_ready & ~i_flush;
      w_bypass    = OUT_REG & w_push & ((r_count == '0) | ((r_count == SIZEW'(1)) & w_pop));
      w_ram_we    = w_push & ~w_bypass;
      w_rd_adv    = w_pop & (~OUT_REG | (r_count > SIZEW'(1)));
      w_count_nxt = i_flush ? '0 : r_count + SIZEW'(w_push) - SIZEW'(w_pop);
      w_wr_nxt    = ADDRW'(wrap_inc(int'(r_wr_ptr), SIZE));
      w_rd_nxt    = ADDRW'(wrap_inc(int'(r_rd_ptr), SIZE));
   end
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         r_count     <= '0;
         r_max       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_full      <= 1'b0;
         r_alm_full  <= 1'b0;
         r_alm_empty <= 1'b1;
      end else begin
         r_count     <= w_count_nxt;
         r_max       <= i_flush ? '0 : (w_count_nxt > r_max) ? w_count_nxt : r_max;
         r_wr_ptr    <= i_flush ? '0 : w_ram_we ? w_wr_nxt : r_wr_ptr;
         r_rd_ptr    <= i_flush ? '0 : w_rd_adv ? w_rd_nxt : r_rd_ptr;
         r_full      <= w_count_nxt == SIZEW'(SIZE);
         r_alm_full  <= ~i_flush & (w_count_nxt >= i_alm_full_thr);
         r_alm_empty <= i_flush | (w_count_nxt <= i_alm_empty_thr);
      end
   always_ff @(posedge i_clk)
      r_dout <= w_bypass ? i_in_data : w_rd_adv ? w_rdata : r_dout;
   RV_dp_ram #(.DATAW(DATAW), .SIZE(SIZE), .ADDRW(ADDRW)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_ram_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_in_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );
   assign o_in_ready  = ~r_full;
   assign o_out_valid = r_count != '0;
   assign o_out_data  = OUT_REG ? r_dout : w_rdata;
   assign o_full      = r_full;
   assign o_alm_full  = r_alm_full;
   assign o_alm_empty = r_alm_empty;
   assign o_size      = r_count;
   assign o_max_size  = r_max;
endmodule

// File: tb/tb_rv_elastic_fifo.sv
// tb_rv_elastic_fifo: three FIFO configurations on shared stimulus, checked against a log-based model
module tb_rv_elastic_fifo;
   logic       clk = 1'b0;
   logic       rst_n, flush, in_valid, out_ready;
   logic [7:0] in_data;
   logic [3:0] thr_af, thr_ae;
   logic [2:0] rdy, vld, ful, af, ae;
   logic [7:0] dout [3];
   logic [2:0] sz_a, mx_a, sz_b, mx_b;
   logic [3:0] sz_c, mx_c;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   rv_elastic_fifo #(.DATAW(8), .SIZE(5), .OUT_REG(0)) u_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(rdy[0]), .o_out_valid(vld[0]), .o_out_data(dout[0]), .i_out_ready(out_ready),
      .i_alm_full_thr(thr_af[2:0]), .i_alm_empty_thr(thr_ae[2:0]), .o_full(ful[0]),
      .o_alm_full(af[0]), .o_alm_empty(ae[0]), .o_size(sz_a), .o_max_size(mx_a));
   rv_elastic_fifo #(.DATAW(8), .SIZE(4), .OUT_REG(1)) u_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(rdy[1]), .o_out_valid(vld[1]), .o_out_data(dout[1]), .i_out_ready(out_ready),
      .i_alm_full_thr(thr_af[2:0]), .i_alm_empty_thr(thr_ae[2:0]), .o_full(ful[1]),
      .o_alm_full(af[1]), .o_alm_empty(ae[1]), .o_size(sz_b), .o_max_size(mx_b));
   rv_elastic_fifo #(.DATAW(8), .SIZE(8), .OUT_REG(0)) u_c (
      .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(rdy[2]), .o_out_valid(vld[2]), .o_out_data(dout[2]), .i_out_ready(out_ready),
      .i_alm_full_thr(thr_af), .i_alm_empty_thr(thr_ae), .o_full(ful[2]),
      .o_alm_full(af[2]), .o_alm_empty(ae[2]), .o_size(sz_c), .o_max_size(mx_c));

   // Model: every accepted word is appended to an unbounded log; occupancy = tail - head
   logic [7:0] hist [3][4096];
   int  hd[3], tl[3], mxm[3];
   bit  eaf[3], eae[3];

   function automatic int depth(input int i);
      return (i == 0) ? 5 : (i == 1) ? 4 : 8;
   endfunction
   function automatic int szv(input int i);
      return (i == 0) ? int'(sz_a) : (i == 1) ? int'(sz_b) : int'(sz_c);
   endfunction
   function automatic int mxv(input int i);
      return (i == 0) ? int'(mx_a) : (i == 1) ? int'(mx_b) : int'(mx_c);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         hd[i] = tl[i]; mxm[i] = 0; eaf[i] = 1'b0; eae[i] = 1'b1;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         int n;
         n = tl[i] - hd[i];
         chk($sformatf("size%0d", i), szv(i), n);
         chk($sformatf("max%0d", i), mxv(i), mxm[i]);
         chk($sformatf("valid%0d", i), int'(vld[i]), int'(n != 0));
         chk($sformatf("full%0d", i), int'(ful[i]), int'(n == depth(i)));
         chk($sformatf("ready%0d", i), int'(rdy[i]), int'(n != depth(i)));
         chk($sformatf("afull%0d", i), int'(af[i]), int'(eaf[i]));
         chk($sformatf("aempty%0d", i), int'(ae[i]), int'(eae[i]));
         if (n != 0) chk($sformatf("data%0d", i), int'(dout[i]), int'(hist[i][hd[i] % 4096]));
      end
   endtask

   task automatic cycle(input bit do_chk);
      bit p[3], q[3];
      int n;
      for (int i = 0; i < 3; i++) begin
         n = tl[i] - hd[i];
         p[i] = in_valid && n != depth(i) && !flush;
         q[i] = out_ready && n != 0 && !flush;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (flush) begin
            hd[i] = tl[i]; mxm[i] = 0; eaf[i] = 1'b0; eae[i] = 1'b1;
         end else begin
            if (q[i]) hd[i]++;
            if (p[i]) begin
               hist[i][tl[i] % 4096] = in_data;
               tl[i]++;
            end
            n = tl[i] - hd[i];
            if (n > mxm[i]) mxm[i] = n;
            eaf[i] = n >= int'(thr_af);
            eae[i] = n <= int'(thr_ae);
         end
      end
      if (do_chk) check_all();
   endtask

   task automatic do_flush();
      flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cycle(1);
      flush = 1'b0;
   endtask

   typedef struct {
      bit iv; bit ordy; logic [7:0] din;
      int e_size; bit e_full; bit e_valid; logic [7:0] e_data;
   } vec_t;
   vec_t tv[12];

   initial begin
      int iv_pct, or_pct;
      tv[0]  = '{1, 0, 8'hA1, 1, 0, 1, 8'hA1};
      tv[1]  = '{1, 0, 8'hA2, 2, 0, 1, 8'hA1};
      tv[2]  = '{1, 0, 8'hA3, 3, 0, 1, 8'hA1};
      tv[3]  = '{1, 0, 8'hA4, 4, 0, 1, 8'hA1};
      tv[4]  = '{1, 0, 8'hA5, 5, 1, 1, 8'hA1};
      tv[5]  = '{1, 0, 8'hEE, 5, 1, 1, 8'hA1};
      tv[6]  = '{0, 1, 8'h00, 4, 0, 1, 8'hA2};
      tv[7]  = '{0, 1, 8'h00, 3, 0, 1, 8'hA3};
      tv[8]  = '{0, 1, 8'h00, 2, 0, 1, 8'hA4};
      tv[9]  = '{0, 1, 8'h00, 1, 0, 1, 8'hA5};
      tv[10] = '{0, 1, 8'h00, 0, 0, 0, 8'h00};
      tv[11] = '{1, 0, 8'hB1, 1, 0, 1, 8'hB1};
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      thr_af = 4'd7; thr_ae = 4'd0;
      for (int i = 0; i < 3; i++) begin hd[i] = 0; tl[i] = 0; end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // SIZE=5 fill, overflow attempt, drain and pointer wrap
      for (int k = 0; k < 12; k++) begin
         in_valid = tv[k].iv; out_ready = tv[k].ordy; in_data = tv[k].din;
         cycle(1);
         chk("tv_size", int'(sz_a), tv[k].e_size);
         chk("tv_full", int'(ful[0]), int'(tv[k].e_full));
         chk("tv_ready", int'(rdy[0]), int'(!tv[k].e_full));
         chk("tv_valid", int'(vld[0]), int'(tv[k].e_valid));
         if (tv[k].e_valid) chk("tv_data", int'(dout[0]), int'(tv[k].e_data));
      end

      // OUT_REG=1: bypass into empty register, then push+pop at count 1
      do_flush();
      in_valid = 1'b1; in_data = 8'h11;
      cycle(1);
      chk("oreg_first", int'(dout[1]), 32'h11);
      chk("oreg_valid", int'(vld[1]), 1);
      in_data = 8'h22; out_ready = 1'b1;
      cycle(1);
      chk("oreg_bypass", int'(dout[1]), 32'h22);
      chk("oreg_size", int'(sz_b), 1);

      // Full with simultaneous pop: pop only, push accepted the cycle after
      do_flush();
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin in_data = 8'h31 + 8'(k); cycle(1); end
      chk("full_b", int'(ful[1]), 1);
      chk("full_rdy_b", int'(rdy[1]), 0);
      in_data = 8'h99; out_ready = 1'b1;
      cycle(1);
      chk("fullpop_size", int'(sz_b), 3);
      chk("fullpop_rdy", int'(rdy[1]), 1);
      chk("fullpop_head", int'(dout[1]), 32'h32);
      out_ready = 1'b0;
      cycle(1);
      chk("refill_size", int'(sz_b), 4);
      chk("refill_full", int'(ful[1]), 1);

      // Thresholds on SIZE=8
      do_flush();
      thr_af = 4'd3; thr_ae = 4'd1; in_valid = 1'b1;
      in_data = 8'h41; cycle(1);
      chk("thr_ae1", int'(ae[2]), 1);
      in_data = 8'h42; cycle(1);
      chk("thr_ae2", int'(ae[2]), 0);
      chk("thr_af2", int'(af[2]), 0);
      in_data = 8'h43; cycle(1);
      chk("thr_af3", int'(af[2]), 1);
      thr_af = 4'd5; in_valid = 1'b0;
      #1;
      chk("thr_hold", int'(af[2]), 1);
      cycle(1);
      chk("thr_new", int'(af[2]), 0);

      // High-watermark then flush with a simultaneous push
      do_flush();
      thr_af = 4'd7; thr_ae = 4'd0; in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin in_data = 8'h60 + 8'(k); cycle(1); end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) cycle(1);
      chk("max6", int'(mx_c), 6);
      chk("size2", int'(sz_c), 2);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
      cycle(1);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_size", int'(sz_c), 0);
      chk("flush_valid", int'(vld[2]), 0);
      chk("flush_max", int'(mx_c), 0);
      cycle(1);
      chk("flush_drop", int'(sz_c), 0);

      // Asynchronous reset mid-burst
      thr_af = 4'd3; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin in_data = 8'h80 + 8'(k); cycle(1); end
      chk("pre_rst_af", int'(af[2]), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_size", int'(sz_c), 0);
      chk("arst_valid", int'(vld[2]), 0);
      chk("arst_af", int'(af[2]), 0);
      chk("arst_ae", int'(ae[2]), 1);
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1; in_data = 8'h5A;
      cycle(1);
      chk("post_rst_data", int'(dout[2]), 32'h5A);
      in_valid = 1'b0;

      // Random traffic with drifting backpressure, flushes and threshold changes
      iv_pct = 5; or_pct = 5;
      for (int c = 0; c < 1500; c++) begin
         if (c % 100 == 0) begin
            iv_pct = $urandom_range(1, 9);
            or_pct = $urandom_range(1, 9);
         end
         in_valid  = $urandom_range(0, 9) < iv_pct;
         out_ready = $urandom_range(0, 9) < or_pct;
         in_data   = 8'($urandom);
         flush     = $urandom_range(0, 63) == 0;
         if ($urandom_range(0, 31) == 0) begin
            thr_af = 4'($urandom_range(0, 7));
            thr_ae = 4'($urandom_range(0, 7));
         end
         cycle(1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
